// File: rtl/h_gate_sequencer.sv
// Sequences a 2-qubit H pass over a 4-amplitude state store. Each pair goes through an
// external fixed-latency gate datapath and is written back to the store when it returns.
module h_gate_sequencer #(
    parameter int W   = 8,
    parameter int LAT = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_valid,
    input  logic [1:0]          load_addr,
    input  logic signed [W-1:0] load_r,
    input  logic signed [W-1:0] load_i,
    input  logic                start,
    input  logic                target,
    output logic                busy,
    output logic                done,
    input  logic [1:0]          rd_addr,
    output logic signed [W-1:0] rd_r,
    output logic signed [W-1:0] rd_i,
    output logic signed [W-1:0] alpha_r,
    output logic signed [W-1:0] alpha_i,
    output logic signed [W-1:0] beta_r,
    output logic signed [W-1:0] beta_i,
    input  logic signed [W-1:0] new_alpha_r,
    input  logic signed [W-1:0] new_alpha_i,
    input  logic signed [W-1:0] new_beta_r,
    input  logic signed [W-1:0] new_beta_i
);

    typedef struct packed {
        logic signed [W-1:0] r;
        logic signed [W-1:0] i;
    } amp_t;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

    state_t     state, state_nx;
    amp_t       store [4];
    logic       tgt;
    logic       issue_idx;
    logic       issue_vld;
    logic [LAT:1] vld_pipe;
    logic [LAT:1] pair_pipe;
    logic       tail_vld;
    logic       tail_pair;
    logic [1:0] iss_lo, iss_hi, wb_lo, wb_hi;

    // target 0 pairs differ in bit 0 of the index, target 1 pairs in bit 1
    function automatic logic [1:0] lo_of(input logic t, input logic p);
        return t ? {1'b0, p} : {p, 1'b0};
    endfunction

    function automatic logic [1:0] hi_of(input logic t, input logic p);
        return t ? {1'b1, p} : {p, 1'b1};
    endfunction

    assign issue_vld = (state == ISSUE);
    assign tail_vld  = vld_pipe[LAT];
    assign tail_pair = pair_pipe[LAT];
    assign iss_lo    = lo_of(tgt, issue_idx);
    assign iss_hi    = hi_of(tgt, issue_idx);
    assign wb_lo     = lo_of(tgt, tail_pair);
    assign wb_hi     = hi_of(tgt, tail_pair);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (start) state_nx = ISSUE;
            ISSUE: if (issue_idx) state_nx = DRAIN;
            DRAIN: if (tail_vld && tail_pair) state_nx = FIN;
            FIN:   state_nx = IDLE;
        endcase
    end

    assign busy    = (state != IDLE);
    assign done    = (state == FIN);
    assign alpha_r = issue_vld ? store[iss_lo].r : '0;
    assign alpha_i = issue_vld ? store[iss_lo].i : '0;
    assign beta_r  = issue_vld ? store[iss_hi].r : '0;
    assign beta_i  = issue_vld ? store[iss_hi].i : '0;
    assign rd_r    = store[rd_addr].r;
    assign rd_i    = store[rd_addr].i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tgt       <= 1'b0;
            issue_idx <= 1'b0;
            vld_pipe  <= '0;
            pair_pipe <= '0;
        end else begin
            if (state == IDLE && start) begin
                tgt       <= target;
                issue_idx <= 1'b0;
            end else if (issue_vld) begin
                issue_idx <= ~issue_idx;
            end
            vld_pipe[1]  <= issue_vld;
            pair_pipe[1] <= issue_idx;
            for (int k = 2; k <= LAT; k++) begin
                vld_pipe[k]  <= vld_pipe[k-1];
                pair_pipe[k] <= pair_pipe[k-1];
            end
        end
    end

    // loads only happen in IDLE and writebacks only mid-pass, so the two never collide
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int a = 0; a < 4; a++) store[a] <= '0;
        end else begin
            if (state == IDLE && load_valid && !start)
                store[load_addr] <= {load_r, load_i};
            if (tail_vld) begin
                store[wb_lo] <= {new_alpha_r, new_alpha_i};
                store[wb_hi] <= {new_beta_r, new_beta_i};
            end
        end
    end

endmodule

// File: tb/tb_h_gate_sequencer.sv
// Directed bench for h_gate_sequencer: three instances (LAT 2, 1, 5) each fed by an
// ideal H-gate model with matching delay.
module tb_h_gate_sequencer;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst, load_valid, start, target;
    logic [1:0] load_addr, rd_addr;
    logic signed [W-1:0] load_r, load_i;

    logic busy_v [3];
    logic done_v [3];
    logic signed [W-1:0] rdr_v [3], rdi_v [3];
    logic signed [W-1:0] ar_v [3], ai_v [3], br_v [3], bi_v [3];

    int checks = 0;
    int failures = 0;
    int done_cyc [3];
    int npulse [3];
    integer a1r, a1i, b1r, b1i, a2r, a2i, b2r, b2i;

    always #5 clk = ~clk;

    function automatic logic signed [W-1:0] hp(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
        int t;
        t = (int'(a) + int'(b)) * 11;
        return W'(t >>> 4);
    endfunction

    function automatic logic signed [W-1:0] hm(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
        int t;
        t = (int'(a) - int'(b)) * 11;
        return W'(t >>> 4);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : u
        localparam int L = (g == 0) ? 2 : ((g == 1) ? 1 : 5);
        logic signed [W-1:0] pa_r [L], pa_i [L], pb_r [L], pb_i [L];

        always @(posedge clk) begin
            pa_r[0] <= hp(ar_v[g], br_v[g]);
            pa_i[0] <= hp(ai_v[g], bi_v[g]);
            pb_r[0] <= hm(ar_v[g], br_v[g]);
            pb_i[0] <= hm(ai_v[g], bi_v[g]);
            for (int k = 1; k < L; k++) begin
                pa_r[k] <= pa_r[k-1];
                pa_i[k] <= pa_i[k-1];
                pb_r[k] <= pb_r[k-1];
                pb_i[k] <= pb_i[k-1];
            end
        end

        h_gate_sequencer #(.W(W), .LAT(L)) dut (
            .clk(clk), .rst(rst),
            .load_valid(load_valid), .load_addr(load_addr), .load_r(load_r), .load_i(load_i),
            .start(start), .target(target), .busy(busy_v[g]), .done(done_v[g]),
            .rd_addr(rd_addr), .rd_r(rdr_v[g]), .rd_i(rdi_v[g]),
            .alpha_r(ar_v[g]), .alpha_i(ai_v[g]), .beta_r(br_v[g]), .beta_i(bi_v[g]),
            .new_alpha_r(pa_r[L-1]), .new_alpha_i(pa_i[L-1]),
            .new_beta_r(pb_r[L-1]), .new_beta_i(pb_i[L-1])
        );
    end

    task automatic chk(input string tag, input integer got, input integer exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic rd_chk(input string tag, input int inst, input int a, input int er, input int ei);
        rd_addr = 2'(a);
        #1;
        chk($sformatf("%s_u%0d_a%0d_r", tag, inst, a), rdr_v[inst], er);
        chk($sformatf("%s_u%0d_a%0d_i", tag, inst, a), rdi_v[inst], ei);
    endtask

    task automatic store_chk(input string tag, input int inst,
                             input int r0, input int i0, input int r1, input int i1,
                             input int r2, input int i2, input int r3, input int i3);
        @(negedge clk);
        rd_chk(tag, inst, 0, r0, i0);
        rd_chk(tag, inst, 1, r1, i1);
        rd_chk(tag, inst, 2, r2, i2);
        rd_chk(tag, inst, 3, r3, i3);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        load_valid = 1'b0;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic load(input int a, input int r, input int i);
        load_valid = 1'b1;
        load_addr  = 2'(a);
        load_r     = W'(r);
        load_i     = W'(i);
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    // inj: 0 none, 1 load+start while busy, 2 load with start, 3 reset in DRAIN
    task automatic run_pass(input logic t, input int inj);
        for (int g = 0; g < 3; g++) begin
            done_cyc[g] = 0;
            npulse[g] = 0;
        end
        start  = 1'b1;
        target = t;
        if (inj == 2) begin
            load_valid = 1'b1; load_addr = 2'd1; load_r = 8'sd50; load_i = 8'sd0;
        end
        @(negedge clk);
        start = 1'b0;
        load_valid = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            for (int g = 0; g < 3; g++) begin
                if (done_v[g] === 1'b1) begin
                    npulse[g]++;
                    if (done_cyc[g] == 0) done_cyc[g] = c;
                end
            end
            if (c == 1) begin
                chk("busy_c1", busy_v[0], 1);
                a1r = ar_v[0]; a1i = ai_v[0]; b1r = br_v[0]; b1i = bi_v[0];
            end
            if (c == 2) begin
                a2r = ar_v[0]; a2i = ai_v[0]; b2r = br_v[0]; b2i = bi_v[0];
            end
            if (c == 3) begin
                chk("alpha_drain", ar_v[0], 0);
                chk("beta_drain", br_v[0], 0);
                if (inj == 3) begin
                    rst = 1'b1;
                    #1;
                    chk("busy_rst", busy_v[0], 0);
                    rd_chk("rst_clr", 0, 0, 0, 0);
                    rd_chk("rst_clr", 0, 1, 0, 0);
                end
            end
            if (inj == 1 && (c == 3 || c == 5)) begin
                load_valid = 1'b1; load_addr = 2'd3; load_r = 8'sd99; load_i = 8'sd99;
                start = 1'b1; target = 1'b0;
            end
            @(negedge clk);
            load_valid = 1'b0;
            start = 1'b0;
        end
        chk("busy_end", busy_v[0], 0);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; load_valid = 1'b0; start = 1'b0; target = 1'b0;
        load_addr = '0; load_r = '0; load_i = '0; rd_addr = '0;
        repeat (2) @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            chk("rst_busy", busy_v[g], 0);
            chk("rst_done", done_v[g], 0);
            chk("rst_alpha", ar_v[g], 0);
            chk("rst_beta", bi_v[g], 0);
        end
        for (int a = 0; a < 4; a++) rd_chk("rst_store", 0, a, 0, 0);
        rst = 1'b0;
        @(negedge clk);

        // basic pass, all three latencies
        load(0, 16, 0);
        run_pass(1'b0, 0);
        chk("lat2_done", done_cyc[0], 5);
        chk("lat1_done", done_cyc[1], 4);
        chk("lat5_done", done_cyc[2], 8);
        for (int g = 0; g < 3; g++) begin
            chk("pulses", npulse[g], 1);
            store_chk("t0", g, 11, 0, 11, 0, 0, 0, 0, 0);
        end

        // target 1
        do_reset();
        load(0, 16, 0);
        run_pass(1'b1, 0);
        chk("t1_done", done_cyc[0], 5);
        chk("t1_a1r", a1r, 16);
        chk("t1_b1r", b1r, 0);
        store_chk("t1", 0, 11, 0, 0, 0, 11, 0, 0, 0);

        // target 1 issue order with distinct amplitudes
        do_reset();
        load(0, 16, 0);
        load(1, 32, 4);
        load(2, -16, 0);
        load(3, 8, -8);
        run_pass(1'b1, 0);
        chk("ord_a1r", a1r, 16);
        chk("ord_a1i", a1i, 0);
        chk("ord_b1r", b1r, -16);
        chk("ord_b1i", b1i, 0);
        chk("ord_a2r", a2r, 32);
        chk("ord_a2i", a2i, 4);
        chk("ord_b2r", b2r, 8);
        chk("ord_b2i", b2i, -8);
        store_chk("ord", 0, 0, 0, 27, -3, 22, 0, 16, 8);

        // load and start while busy are ignored
        do_reset();
        load(0, 16, 0);
        run_pass(1'b0, 1);
        chk("busy_pulses", npulse[0], 1);
        chk("busy_done", done_cyc[0], 5);
        store_chk("busy", 0, 11, 0, 11, 0, 0, 0, 0, 0);

        // start wins over a same-cycle load
        do_reset();
        load(0, 16, 0);
        run_pass(1'b0, 2);
        chk("same_done", done_cyc[0], 5);
        store_chk("same", 0, 11, 0, 11, 0, 0, 0, 0, 0);

        // reset during DRAIN, then a fresh pass
        do_reset();
        load(0, 16, 0);
        run_pass(1'b0, 3);
        chk("rst_pulses", npulse[0], 0);
        store_chk("rstd", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        load(0, 16, 0);
        run_pass(1'b0, 0);
        chk("fresh_done", done_cyc[0], 5);
        chk("fresh_pulses", npulse[0], 1);
        store_chk("fresh", 0, 11, 0, 11, 0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/h_gate_sequencer.md
H_GATE_SEQUENCER -- requirements
Module: h_gate_sequencer

Interface
REQ-001 The block SHALL have parameter W, default 8, giving the signed S3.4 fixed-point amplitude component width.
REQ-002 The block SHALL have parameter LAT, default 2, giving the fixed latency in clocks of the external pipelined H-gate datapath (range 1..8).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, with all state on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have ports load_valid (input, 1), load_addr (input, 2), load_r/load_i (input, W signed): write one complex amplitude into the 4-entry state store.
REQ-006 The block SHALL have ports start (input, 1) and target (input, 1): begin an H pass on qubit 0 or qubit 1.
REQ-007 The block SHALL have ports busy (output, 1) and done (output, 1): pass in progress, and a one-cycle completion pulse.
REQ-008 The block SHALL have ports rd_addr (input, 2) and rd_r/rd_i (output, W signed): combinational read of the state store.
REQ-009 The block SHALL have ports alpha_r/alpha_i/beta_r/beta_i (output, W signed): the amplitude pair driven to the gate datapath.
REQ-010 The block SHALL have ports new_alpha_r/new_alpha_i/new_beta_r/new_beta_i (input, W signed): the gate datapath results, valid LAT cycles after issue.

Function
REQ-011 The FSM SHALL have the states IDLE, ISSUE, DRAIN and FIN.
REQ-012 In IDLE, load_valid SHALL write store[load_addr] on the clock edge; in any other state, load_valid SHALL be ignored.
REQ-013 In IDLE, start SHALL latch target, go to ISSUE and assert busy from the next cycle; in any other state, start SHALL be ignored.
REQ-014 When start and load_valid are both high in IDLE in the same cycle, start SHALL win and the load SHALL be dropped.
REQ-015 Pair ordering: target=0 SHALL issue pairs (0,1) then (2,3); target=1 SHALL issue (0,2) then (1,3); alpha = lower index, beta = higher index.
REQ-016 ISSUE SHALL last exactly 2 cycles, driving pair 0 then pair 1 on alpha/beta, then go to DRAIN.
REQ-017 Issue tracking SHALL use a LAT-deep shift register of {valid, pair index}, pushed once per issue cycle.
REQ-018 When the shift-register tail is valid, new_alpha SHALL be written to store[lower index] and new_beta to store[higher index] of that pair, on the same edge.
REQ-019 Results SHALL be stored unmodified at W bits, with no rounding or saturation by this block.
REQ-020 DRAIN SHALL go to FIN on the edge that captures the second result; FIN SHALL assert done for 1 cycle and return to IDLE.
REQ-021 busy SHALL be high in ISSUE, DRAIN and FIN.
REQ-022 Outside ISSUE, alpha/beta outputs SHALL be driven to 0.
REQ-023 Total time from start to done SHALL be LAT+3 cycles: start sampled at edge 0, done high in the cycle after edge LAT+2.
REQ-024 rd_r/rd_i SHALL reflect store[rd_addr] in every state, showing post-write values from the cycle after each write.
REQ-025 A pass SHALL read source amplitudes only during ISSUE, so writebacks during DRAIN do not affect issued pairs.

Reset
REQ-026 While rst is high, the FSM SHALL be in IDLE.
REQ-027 While rst is high, busy=0, done=0, all store entries SHALL be 0, the shift register SHALL be cleared, and alpha/beta = 0.
REQ-028 Reset asserted mid-pass SHALL discard all in-flight results; after rst falls, the first start SHALL run a full fresh pass.

Verification
REQ-029 Bench SHALL model the gate as an ideal H: out = ((a±b)*11)>>>4, delayed LAT=2.
REQ-030 Scenario: load store={(16,0),0,0,0}, start target=0 -> done at cycle 5; store={(11,0),(11,0),0,0}.
REQ-031 Scenario: same load, start target=1 -> store={(11,0),0,(11,0),0}; issue order (0,2) then (1,3) checked on alpha/beta.
REQ-032 Scenario: load_valid to addr 3 and start while busy -> store[3] unchanged, no second pass, exactly one done pulse.
REQ-033 Scenario: start and load_valid in the same IDLE cycle -> load dropped, pass runs on the prior store contents.
REQ-034 Scenario: rst asserted in DRAIN -> busy=0 and store all-zero immediately; no done pulse; the next pass behaves as in REQ-030.
REQ-035 Scenario: repeat REQ-030 with LAT=1 and LAT=5 -> done at cycles 4 and 8, same store results.
